// File: rtl/iterative_alu.sv
// Multi-cycle ALU with a valid/ready request side and a valid/ready result side.
// Single-cycle ops (ADD, SUB, XOR, OR, AND, SLT, BEQ, illegal) complete at the
// accept edge. Shifts walk one bit per cycle. MUL is a 32-step shift-add, built
// only when the ALU_MUL_EN macro is defined; otherwise opcode 1010 is illegal.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   request valid (Operation/SrcA/SrcB stable)
//   in_ready   block can accept a request (IDLE only)
//   Operation  4-bit opcode
//   SrcA, SrcB WIDTH-bit operands
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   ALUResult  registered result
//   Zero       registered flag, ALUResult == 0
//
// Configuration macro: ALU_MUL_EN (enables the MUL state and datapath).
module iterative_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned CNT_W   = 6;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1010;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef ALU_MUL_EN
  localparam logic [1:0] S_MUL   = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [3:0]       op_q,        op_d;
  logic [WIDTH-1:0] work_q,      work_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [WIDTH-1:0] mul_sum;
`endif

  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  logic [WIDTH-1:0]   fast_res;
  logic [WIDTH-1:0]   shift_step;

  assign shamt    = SrcB[SHAMT_W-1:0];
  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) ||
                    (Operation == OP_SRA);

  // Result of every op that finishes at the accept edge (shifts only for shamt 0).
  always_comb begin
    fast_res = '0;
    case (Operation)
      OP_ADD:  fast_res = SrcA + SrcB;
      OP_SUB:  fast_res = SrcA - SrcB;
      OP_XOR:  fast_res = SrcA ^ SrcB;
      OP_OR:   fast_res = SrcA | SrcB;
      OP_AND:  fast_res = SrcA & SrcB;
      OP_SLL:  fast_res = SrcA;
      OP_SRL:  fast_res = SrcA;
      OP_SRA:  fast_res = SrcA;
      OP_BEQ:  fast_res = SrcA - SrcB;
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: fast_res = '0;
    endcase
  end

  // One bit position of the captured shift.
  always_comb begin
    shift_step = work_q;
    case (op_q)
      OP_SLL:  shift_step = {work_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  shift_step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shift_step = work_q;
    endcase
  end

`ifdef ALU_MUL_EN
  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  assign mul_sum = mplier_q[0] ? (work_q + mcand_q) : work_q;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = Operation;
          work_d = SrcA;
          if (is_shift && (shamt != '0)) begin
            state_d = S_SHIFT;
            cnt_d   = CNT_W'(shamt);
          end
`ifdef ALU_MUL_EN
          else if (Operation == OP_MUL) begin
            state_d  = S_MUL;
            work_d   = '0;
            mcand_d  = SrcA;
            mplier_d = SrcB;
            cnt_d    = CNT_W'(WIDTH);
          end
`endif
          else begin
            state_d  = S_DONE;
            result_d = fast_res;
            zero_d   = (fast_res == '0);
          end
        end
      end

      S_SHIFT: begin
        work_d = shift_step;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = shift_step;
          zero_d   = (shift_step == '0);
        end
      end

`ifdef ALU_MUL_EN
      S_MUL: begin
        work_d   = mul_sum;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = mul_sum;
          zero_d   = (mul_sum == '0);
        end
      end
`endif

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed self-checking bench for iterative_alu: reset, single-cycle ops,
// shifts, MUL/illegal handling, backpressure, back-to-back and mid-op reset.
module tb_iterative_alu;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Operation = 4'b0;
  logic [31:0] SrcA = 32'b0;
  logic [31:0] SrcB = 32'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  iterative_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  // Issue one request, scramble the inputs while busy, wait (bounded) for
  // out_valid, capture result, then complete the output handshake.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic z);
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Operation = OP_ADD; SrcA = 32'h5A5A_A5A5; SrcB = 32'h0000_0003;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = ALUResult;
    z   = Zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (ALUResult !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", ALUResult); else passed++;
    checks++; if (Zero !== 1'b1) $display("FAIL reset_zero: got %b expected 1", Zero); else passed++;
  endtask

  task automatic test_add();
    int lat; logic [31:0] res; logic z;
    do_op(OP_ADD, 32'd7, 32'd5, lat, res, z);
    checks++; if (lat !== 1) $display("FAIL add_latency: got %0d expected 1", lat); else passed++;
    checks++; if (res !== 32'd12) $display("FAIL add_result: got %h expected 0000000c", res); else passed++;
    checks++; if (z !== 1'b0) $display("FAIL add_zero: got %b expected 0", z); else passed++;
  endtask

  task automatic test_alu_ops();
    logic [3:0]  t_op [8];
    logic [31:0] t_a [8];
    logic [31:0] t_b [8];
    logic [31:0] t_r [8];
    int lat; logic [31:0] res; logic z;
    t_op = '{OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLT, OP_SLT, OP_SLT, OP_ADD};
    t_a  = '{32'd3, 32'hF0F0_0000, 32'h0000_00F0, 32'hFF00_FF00,
             32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    t_b  = '{32'd5, 32'h0FF0_0000, 32'h0000_000F, 32'h0FF0_0FF0,
             32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
    t_r  = '{32'hFFFF_FFFE, 32'hFF00_0000, 32'h0000_00FF, 32'h0F00_0F00,
             32'd1, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], lat, res, z);
      checks++; if (res !== t_r[i]) $display("FAIL op%0d_result: got %h expected %h", i, res, t_r[i]); else passed++;
      checks++; if (z !== (t_r[i] == 32'h0)) $display("FAIL op%0d_zero: got %b expected %b", i, z, (t_r[i] == 32'h0)); else passed++;
      checks++; if (lat !== 1) $display("FAIL op%0d_latency: got %0d expected 1", i, lat); else passed++;
    end
  endtask

  task automatic test_beq();
    int lat; logic [31:0] res; logic z;
    do_op(OP_BEQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, res, z);
    checks++; if (res !== 32'h0) $display("FAIL beq_eq_result: got %h expected 00000000", res); else passed++;
    checks++; if (z !== 1'b1) $display("FAIL beq_eq_zero: got %b expected 1", z); else passed++;
    checks++; if (lat !== 1) $display("FAIL beq_latency: got %0d expected 1", lat); else passed++;
    do_op(OP_BEQ, 32'hDEAD_BEEF, 32'h0, lat, res, z);
    checks++; if (res !== 32'hDEAD_BEEF) $display("FAIL beq_ne_result: got %h expected deadbeef", res); else passed++;
    checks++; if (z !== 1'b0) $display("FAIL beq_ne_zero: got %b expected 0", z); else passed++;
  endtask

  task automatic test_shifts();
    logic [3:0]  t_op [7];
    logic [31:0] t_a [7];
    logic [31:0] t_b [7];
    logic [31:0] t_r [7];
    int          t_l [7];
    int lat; logic [31:0] res; logic z;
    t_op = '{OP_SRA, OP_SRA, OP_SRA, OP_SRA, OP_SLL, OP_SRL, OP_SLL};
    t_a  = '{32'h8000_0000, 32'h1234_5678, 32'h4000_0000, 32'h8000_0000,
             32'd1, 32'h8000_0000, 32'd3};
    t_b  = '{32'd4, 32'd0, 32'd2, 32'd31, 32'd31, 32'd31, 32'h25};
    t_r  = '{32'hF800_0000, 32'h1234_5678, 32'h1000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 32'd1, 32'h60};
    t_l  = '{5, 1, 3, 32, 32, 32, 6};
    for (int i = 0; i < 7; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], lat, res, z);
      checks++; if (res !== t_r[i]) $display("FAIL shift%0d_result: got %h expected %h", i, res, t_r[i]); else passed++;
      checks++; if (lat !== t_l[i]) $display("FAIL shift%0d_latency: got %0d expected %0d", i, lat, t_l[i]); else passed++;
    end
    do_op(OP_SLL, 32'h8000_0000, 32'd1, lat, res, z);
    checks++; if (res !== 32'h0 || z !== 1'b1) $display("FAIL sll_out_zero: got %h/%b expected 00000000/1", res, z); else passed++;
  endtask

  task automatic test_mul_and_illegal();
    int lat; logic [31:0] res; logic z;
`ifdef ALU_MUL_EN
    do_op(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, lat, res, z);
    checks++; if (res !== 32'hFFFF_FFFF) $display("FAIL mul_result: got %h expected ffffffff", res); else passed++;
    checks++; if (z !== 1'b0) $display("FAIL mul_zero: got %b expected 0", z); else passed++;
    checks++; if (lat !== 33) $display("FAIL mul_latency: got %0d expected 33", lat); else passed++;
    do_op(OP_MUL, 32'd7, 32'd6, lat, res, z);
    checks++; if (res !== 32'd42) $display("FAIL mul_small_result: got %h expected 0000002a", res); else passed++;
`else
    do_op(OP_ADD, 32'd1, 32'd1, lat, res, z);
    do_op(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, lat, res, z);
    checks++; if (res !== 32'h0) $display("FAIL mul_off_result: got %h expected 00000000", res); else passed++;
    checks++; if (z !== 1'b1) $display("FAIL mul_off_zero: got %b expected 1", z); else passed++;
    checks++; if (lat !== 1) $display("FAIL mul_off_latency: got %0d expected 1", lat); else passed++;
`endif
    do_op(OP_ADD, 32'd2, 32'd2, lat, res, z);
    do_op(4'b1111, 32'd9, 32'd9, lat, res, z);
    checks++; if (res !== 32'h0 || z !== 1'b1) $display("FAIL illegal_result: got %h/%b expected 00000000/1", res, z); else passed++;
    checks++; if (lat !== 1) $display("FAIL illegal_latency: got %0d expected 1", lat); else passed++;
  endtask

  task automatic test_backpressure();
    int wait_cyc;
    bit held_ok;
    @(negedge clk);
    Operation = OP_SUB; SrcA = 32'd3; SrcB = 32'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    wait_cyc = 0;
    while (out_valid !== 1'b1 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== 32'hFFFF_FFFE || Zero !== 1'b0) begin
        held_ok = 1'b0;
        $display("FAIL bp_hold_cycle%0d: got valid=%b ready=%b result=%h zero=%b expected 1/0/fffffffe/0",
                 i, out_valid, in_ready, ALUResult, Zero);
      end
      @(negedge clk);
    end
    checks++; if (held_ok !== 1'b1) $display("FAIL bp_hold: got %b expected 1", held_ok); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    Operation = OP_ADD; SrcA = 32'd10; SrcB = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || ALUResult !== 32'd30) $display("FAIL b2b_first: got %b/%h expected 1/0000001e", out_valid, ALUResult); else passed++;
    Operation = OP_XOR; SrcA = 32'hAAAA_0000; SrcB = 32'h0000_5555;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_gap: got ready=%b valid=%b expected 1/0", in_ready, out_valid); else passed++;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || ALUResult !== 32'hAAAA_5555) $display("FAIL b2b_second: got %b/%h expected 1/aaaa5555", out_valid, ALUResult); else passed++;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    bit saw_valid;
    @(negedge clk);
    Operation = OP_SLL; SrcA = 32'd1; SrcB = 32'd20; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (ALUResult !== 32'h0 || Zero !== 1'b1) $display("FAIL rst_mid_result: got %h/%b expected 00000000/1", ALUResult, Zero); else passed++;
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++; if (saw_valid !== 1'b0) $display("FAIL rst_mid_no_valid: got %b expected 0", saw_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_mid_idle: got %b expected 1", in_ready); else passed++;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_beq();
    test_shifts();
    test_mul_and_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 in_valid  input  1  request valid: Operation, SrcA and SrcB are stable.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 Operation  input  4  ALU operation code, encoding per REQ-010.
REQ-007 SrcA, SrcB  input  WIDTH each  operands.
REQ-008 out_valid, out_ready  output, input  1 each  result handshake.
REQ-009 ALUResult  output  WIDTH, Zero  output  1  registered result, and flag (ALUResult == 0).

Function
REQ-010 Encoding: 0000 ADD, 0001 SUB, 0010 XOR, 0011 OR, 0100 AND, 0101 SLL, 0110 SRL, 0111 SRA, 1000 BEQ, 1001 SLT, 1010 MUL; all other codes are illegal.
REQ-011 FSM states: IDLE, SHIFT, MUL, DONE; in_ready = 1 only in IDLE.
REQ-012 Accept occurs when in_valid && in_ready are high at a rising edge; operands and opcode are captured at that edge.
REQ-013 ADD/SUB/XOR/OR/AND/SLT/BEQ: result is registered at the accept edge, IDLE->DONE, out_valid is high the next cycle (latency 1).
REQ-014 BEQ result = SrcA - SrcB, so Zero = 1 exactly when SrcA == SrcB; SLT is a signed compare with result 1 or 0.
REQ-015 Arithmetic is modulo 2^WIDTH; no overflow flag.
REQ-016 Shifts: shamt = SrcB[4:0]; shamt = 0 goes straight to DONE (latency 1); otherwise SHIFT performs one bit position per cycle, giving latency shamt+1.
REQ-017 SRA replicates SrcA[31] on each step; SRL and SLL fill with 0.
REQ-018 MUL (only with ALU_MUL_EN): shift-add, one multiplier bit per cycle for 32 cycles, then DONE; result = low 32 bits of the product; latency 33.
REQ-019 DONE: out_valid = 1, and ALUResult/Zero are held stable until out_ready is seen high at a rising edge; then DONE->IDLE.
REQ-020 Back-to-back: next accept is possible no earlier than the cycle after the out handshake; throughput for single-cycle ops is one per 2 cycles.
REQ-021 Illegal opcode, or MUL with ALU_MUL_EN undefined: result = 0, Zero = 1, latency 1; no hang.
REQ-022 Input changes while not in IDLE are ignored.

Reset
REQ-023 reset_n low at an edge forces IDLE, out_valid = 0, ALUResult = 0, and clears the iteration counter; Zero = 1 as a consequence.
REQ-024 Reset mid-SHIFT, mid-MUL or in DONE aborts the operation; no out_valid pulse follows.
REQ-025 in_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-026 Macro ALU_MUL_EN: when defined, opcode 1010 performs MUL per REQ-018 and the MUL state, multiplicand/multiplier registers and adder are present.
REQ-027 Without ALU_MUL_EN: the MUL state and its logic are absent, and 1010 is treated as illegal per REQ-021.

Verification
REQ-028 ADD: SrcA = 7, SrcB = 5, out_ready = 1 -> out_valid 1 cycle after accept, ALUResult = 12, Zero = 0.
REQ-029 BEQ: SrcA = SrcB = 0xDEADBEEF -> ALUResult = 0, Zero = 1; SrcB = 0 -> Zero = 0.
REQ-030 SRA: SrcA = 0x80000000, SrcB = 4 -> out_valid 5 cycles after accept, ALUResult = 0xF8000000; shamt = 0 -> latency 1, result = SrcA.
REQ-031 Backpressure: out_ready held 0 for 10 cycles after SUB 3-5 -> ALUResult = 0xFFFFFFFE held, in_ready = 0 throughout, then IDLE one cycle after the handshake.
REQ-032 Reset mid-SLL (SrcB = 20, reset_n low at cycle 6) -> out_valid never asserts, ALUResult = 0, in_ready = 1 after release.
REQ-033 MUL 0xFFFF*0x10001 with ALU_MUL_EN -> result 0xFFFFFFFF at latency 33; without the macro -> result 0, Zero = 1, latency 1.
